// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: redirect bus width, reset vector, FSM encoding.
package inst_fetch_pkg;

   localparam int unsigned BR_WD = 33;
   localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

   typedef enum logic [1:0] {
      StReq  = 2'd0,
      StWait = 2'd1,
      StHold = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] align8(input logic [31:0] pc);
      return {pc[31:3], 3'b000};
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry fetch packet buffer between instruction memory and decode.
module fetch_buf (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic        consume,
   input  logic        flush,
   input  logic [31:0] load_pc,
   input  logic [63:0] load_inst,
   output logic        valid,
   output logic [31:0] pc,
   output logic [63:0] inst
);

   logic        valid_q, valid_d;
   logic [31:0] pc_q;
   logic [63:0] inst_q;

   // Flush wins over a same-cycle load; load wins over consume.
   always_comb begin
      valid_d = valid_q;
      if (consume) valid_d = 1'b0;
      if (load)    valid_d = 1'b1;
      if (flush)   valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= '0;
      end else begin
         valid_q <= valid_d;
         if (load) begin
            pc_q   <= load_pc;
            inst_q <= load_inst;
         end
      end
   end

   assign valid = valid_q;
   assign pc    = pc_q;
   assign inst  = inst_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding 64-bit request, redirect handling and
// a single-entry output buffer towards decode.
module inst_fetch
   import inst_fetch_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             stall,
   input  logic [BR_WD-1:0] br_bus,
   input  logic [BR_WD-1:0] bp_bus,
   output logic             inst_sram_req,
   output logic [31:0]      inst_sram_addr,
   input  logic             inst_sram_addr_ok,
   input  logic             inst_sram_data_ok,
   input  logic [63:0]      inst_sram_rdata,
   output logic             fd_valid,
   output logic [31:0]      fd_pc,
   output logic [63:0]      fd_inst
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic         cancel_q, cancel_d;

   logic        br_e, bp_e, redirect;
   logic [31:0] br_addr, bp_addr, redirect_pc;
   logic        addr_fire, data_fire, data_good;
   logic        buf_ready, buf_load, buf_consume, replay;

   assign br_e    = br_bus[BR_WD-1];
   assign br_addr = br_bus[31:0];
   assign bp_e    = bp_bus[BR_WD-1];
   assign bp_addr = bp_bus[31:0];

   assign redirect    = br_e | (bp_e & ~stall);
   assign redirect_pc = br_e ? br_addr : bp_addr;

   assign inst_sram_req  = (state_q == StReq);
   assign inst_sram_addr = align8(fetch_pc_q);

   assign addr_fire   = inst_sram_req & inst_sram_addr_ok;
   assign data_fire   = (state_q == StWait) & inst_sram_data_ok;
   assign data_good   = data_fire & ~cancel_q & ~redirect;
   assign buf_ready   = ~fd_valid | ~stall;
   assign buf_load    = data_good & buf_ready;
   assign buf_consume = fd_valid & ~stall;
   // Data landing on a full, stalled buffer is dropped and refetched later.
   assign replay      = data_good & ~buf_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StReq: begin
            if (addr_fire) state_d = StWait;
         end
         StWait: begin
            if (data_fire) begin
               if (!redirect && stall && (fd_valid || buf_load)) state_d = StHold;
               else                                               state_d = StReq;
            end
         end
         StHold: begin
            if (redirect || !stall) state_d = StReq;
         end
         default: state_d = StReq;
      endcase
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect)       fetch_pc_d = redirect_pc;
      else if (replay)    fetch_pc_d = req_pc_q;
      else if (addr_fire) fetch_pc_d = inst_sram_addr + 32'd8;

      req_pc_d = addr_fire ? fetch_pc_q : req_pc_q;

      // A redirect while a request is (or is becoming) outstanding poisons its data.
      cancel_d = cancel_q;
      if (data_fire) cancel_d = 1'b0;
      if (redirect && (addr_fire || ((state_q == StWait) && !inst_sram_data_ok))) begin
         cancel_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StReq;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         cancel_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         cancel_q   <= cancel_d;
      end
   end

   fetch_buf u_fetch_buf (
      .clk       (clk),
      .resetn    (resetn),
      .load      (buf_load),
      .consume   (buf_consume),
      .flush     (redirect),
      .load_pc   (req_pc_q),
      .load_inst (inst_sram_rdata),
      .valid     (fd_valid),
      .pc        (fd_pc),
      .inst      (fd_inst)
   );

endmodule
